uart_tx_sched: RTL and testbench

Frame scheduler for the shared UART transmitter. It arbitrates among four byte requesters and latches the winning byte. It also paces the transmitter with one-cycle bit enables at the baud rate and enforces an idle gap between frames. It sits between the application-side byte sources and the bit-serial transmitter, which shifts one frame bit per `bit_en`.

---
 rtl/uart_tx_sched.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Frame scheduler for the shared UART transmitter: four-way byte arbitration, baud-rate
// bit enables and an idle gap after each frame. Define UART_SCHED_STRICT0_EN for fixed priority.
module uart_tx_sched #(
   parameter int BAUD_DIV   = 16,
   parameter int FRAME_BITS = 11,
   parameter int GAP_BITS   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req_valid,
   input  logic [31:0] req_data,
   output logic [3:0]  req_ready,
   output logic        tx_go,
   output logic [7:0]  tx_data,
   output logic        bit_en,
   output logic        busy,
   output logic [1:0]  grant_id,
   output logic        frame_done
);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   localparam logic [15:0] BAUD_LAST  = 16'(BAUD_DIV - 1);
   localparam logic [3:0]  FRAME_LAST = 4'(FRAME_BITS - 1);
   localparam logic [3:0]  GAP_LAST   = 4'(GAP_BITS - 1);

   state_t      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [3:0]  bit_q, bit_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic [1:0]  grant_q, grant_d;
   logic [3:0]  ready_q, ready_d;
   logic        go_q, go_d;
   logic        bit_en_q, bit_en_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [1:0]  win;
   logic [3:0]  win_oh;

`ifdef UART_SCHED_STRICT0_EN
   always_comb begin
      win = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (req_valid[i]) win = 2'(i);
      end
   end
`else
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] rr_idx;

   // Scan downward so the nearest requester after the pointer is the last (winning) assignment.
   always_comb begin
      win    = ptr_q;
      rr_idx = ptr_q;
      for (int k = 4; k >= 1; k--) begin
         rr_idx = ptr_q + 2'(k);
         if (req_valid[rr_idx]) win = rr_idx;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (state_q == IDLE && (|req_valid)) ptr_d = win;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= 2'd3;
      else       ptr_q <= ptr_d;
   end
`endif

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
         assign win_oh[gi] = (win == 2'(gi));
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      tx_data_d = tx_data_q;
      grant_d   = grant_q;
      ready_d   = 4'd0;
      go_d      = 1'b0;
      bit_en_d  = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               state_d   = SEND;
               baud_d    = 16'd0;
               bit_d     = 4'd0;
               tx_data_d = req_data[{win, 3'b000} +: 8];
               grant_d   = win;
               ready_d   = win_oh;
               go_d      = 1'b1;
               bit_en_d  = 1'b1;
            end
         end
         SEND: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = 16'd0;
               if (bit_q == FRAME_LAST) begin
                  bit_d   = 4'd0;
                  state_d = (GAP_BITS == 0) ? IDLE : GAP;
               end else begin
                  bit_d    = bit_q + 4'd1;
                  bit_en_d = 1'b1;
               end
            end else begin
               baud_d = baud_q + 16'd1;
               // Registered output: flag the cycle before the final stop-bit cycle.
               done_d = (baud_d == BAUD_LAST) && (bit_q == FRAME_LAST);
            end
         end
         GAP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = 16'd0;
               if (bit_q == GAP_LAST) begin
                  bit_d   = 4'd0;
                  state_d = IDLE;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         baud_q    <= 16'd0;
         bit_q     <= 4'd0;
         tx_data_q <= 8'd0;
         grant_q   <= 2'd0;
         ready_q   <= 4'd0;
         go_q      <= 1'b0;
         bit_en_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         tx_data_q <= tx_data_d;
         grant_q   <= grant_d;
         ready_q   <= ready_d;
         go_q      <= go_d;
         bit_en_q  <= bit_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign req_ready  = ready_q;
   assign tx_go      = go_q;
   assign tx_data    = tx_data_q;
   assign bit_en     = bit_en_q;
   assign busy       = busy_q;
   assign grant_id   = grant_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: default instance plus a GAP_BITS=0, BAUD_DIV=4 instance.
module tb_uart_tx_sched;

   localparam int A_DIV = 16;
   localparam int A_FB  = 11;
   localparam int A_GAP = 1;
   localparam int A_PERIOD = (A_FB + A_GAP) * A_DIV;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  a_valid = 4'd0;
   logic [31:0] a_data = 32'd0;
   logic [3:0]  a_ready;
   logic        a_go, a_bit_en, a_busy, a_done;
   logic [7:0]  a_txd;
   logic [1:0]  a_gid;

   logic [3:0]  b_valid = 4'd0;
   logic [31:0] b_data = 32'd0;
   logic [3:0]  b_ready;
   logic        b_go, b_bit_en, b_busy, b_done;
   logic [7:0]  b_txd;
   logic [1:0]  b_gid;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_sched dut_a (
      .clk(clk), .reset(reset), .req_valid(a_valid), .req_data(a_data),
      .req_ready(a_ready), .tx_go(a_go), .tx_data(a_txd), .bit_en(a_bit_en),
      .busy(a_busy), .grant_id(a_gid), .frame_done(a_done)
   );

   uart_tx_sched #(.BAUD_DIV(4), .FRAME_BITS(11), .GAP_BITS(0)) dut_b (
      .clk(clk), .reset(reset), .req_valid(b_valid), .req_data(b_data),
      .req_ready(b_ready), .tx_go(b_go), .tx_data(b_txd), .bit_en(b_bit_en),
      .busy(b_busy), .grant_id(b_gid), .frame_done(b_done)
   );

   typedef struct {
      logic [3:0] valid;
      logic [1:0] g_rr;
      logic [1:0] g_strict;
   } vec_t;

   typedef struct {
      logic [1:0] gid;
      logic [7:0] data;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_go_a(output bit found);
      found = 1'b0;
      for (int i = 0; i < 600; i++) begin
         step();
         if (a_go) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   // Called in the tx_go cycle; returns in the first IDLE cycle after the gap.
   task automatic check_frame(input logic [1:0] g, input logic [7:0] d);
      int e_be = 0, e_done = 0, e_busy = 0, e_ready = 0, e_data = 0, n_be = 0;
      for (int c = 0; c <= A_PERIOD; c++) begin
         if (c > 0) step();
         if (a_bit_en !== ((c % A_DIV == 0) && (c < A_FB * A_DIV))) e_be++;
         if (a_bit_en) n_be++;
         if (a_done !== (c == A_FB * A_DIV - 1)) e_done++;
         if (a_busy !== (c < A_PERIOD)) e_busy++;
         if (a_ready !== ((c == 0) ? (4'd1 << g) : 4'd0)) e_ready++;
         if (a_txd !== d || a_gid !== g) e_data++;
      end
      chk("frame_bit_en_timing", e_be, 0);
      chk("frame_bit_en_count", n_be, A_FB);
      chk("frame_done_timing", e_done, 0);
      chk("frame_busy_window", e_busy, 0);
      chk("frame_ready_pulse", e_ready, 0);
      chk("frame_data_stable", e_data, 0);
   endtask

   vec_t tab[11];

   initial begin
      bit found;
      int last_go;
      exp_t e;
      logic [1:0] g;
      logic [7:0] d;

      tab[0]  = '{4'b1111, 2'd0, 2'd0};
      tab[1]  = '{4'b1111, 2'd1, 2'd0};
      tab[2]  = '{4'b1111, 2'd2, 2'd0};
      tab[3]  = '{4'b1111, 2'd3, 2'd0};
      tab[4]  = '{4'b1111, 2'd0, 2'd0};
      tab[5]  = '{4'b1010, 2'd1, 2'd1};
      tab[6]  = '{4'b1010, 2'd3, 2'd1};
      tab[7]  = '{4'b0110, 2'd1, 2'd1};
      tab[8]  = '{4'b0100, 2'd2, 2'd2};
      tab[9]  = '{4'b1001, 2'd3, 2'd0};
      tab[10] = '{4'b1001, 2'd0, 2'd0};

      // Reset state
      repeat (3) step();
      chk("reset_outputs_a", {a_ready, a_go, a_txd, a_bit_en, a_busy, a_gid, a_done}, 0);
      chk("reset_outputs_b", {b_ready, b_go, b_txd, b_bit_en, b_busy, b_gid, b_done}, 0);
      reset = 1'b0;
      step();

      // Single byte from requester 0
      a_data = 32'h000000A5;
      a_valid = 4'b0001;
      wait_go_a(found);
      chk("single_go_seen", found, 1);
      a_valid = 4'b0000;
      chk("single_tx_data", a_txd, 8'hA5);
      chk("single_grant", a_gid, 0);
      check_frame(2'd0, 8'hA5);
      $display("single byte: grant=%0d data=%02h", a_gid, a_txd);

      // Reset mid-frame, then first grant goes to requester 0
      a_data = 32'h43322110;
      a_valid = 4'b0010;
      wait_go_a(found);
      chk("midreset_go_seen", found, 1);
      a_valid = 4'b0000;
      repeat (50) step();
      #2;
      reset = 1'b1;
      #1;
      chk("midreset_outputs_zero", {a_ready, a_go, a_txd, a_bit_en, a_busy, a_gid, a_done}, 0);
      step();
      reset = 1'b0;
      a_valid = 4'b0011;
      wait_go_a(found);
      chk("postreset_go_seen", found, 1);
      a_valid = 4'b0000;
      chk("postreset_grant", a_gid, 0);
      check_frame(2'd0, 8'h10);
      $display("reset mid-frame: post-reset grant=%0d", a_gid);

      // Fresh pointer for the table run
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();

      a_valid = tab[0].valid;
`ifdef UART_SCHED_STRICT0_EN
      g = tab[0].g_strict;
`else
      g = tab[0].g_rr;
`endif
      d = a_data[8*g +: 8];
      sb.push_back('{g, d});
      last_go = 0;
      for (int i = 0; i < 11; i++) begin
         wait_go_a(found);
         chk("table_go_seen", found, 1);
         if (!found) break;
         if (i > 0) chk("table_go_spacing", cyc - last_go, A_PERIOD + 1);
         last_go = cyc;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("table_grant", a_gid, e.gid);
            chk("table_tx_data", a_txd, e.data);
            $display("table vec %0d: valid=%b grant=%0d data=%02h", i, a_valid, a_gid, a_txd);
         end else begin
            e = '{a_gid, a_txd};
            chk("table_scoreboard_empty", sb.size(), 1);
         end
         if (i + 1 < 11) begin
            a_valid = tab[i + 1].valid;
`ifdef UART_SCHED_STRICT0_EN
            g = tab[i + 1].g_strict;
`else
            g = tab[i + 1].g_rr;
`endif
            d = a_data[8*g +: 8];
            sb.push_back('{g, d});
         end else begin
            a_valid = 4'b0000;
         end
         check_frame(e.gid, e.data);
      end

      // Late request: requester 1 rises while requester 0 is being sent
      a_data = 32'h43327710;
      a_valid = 4'b0001;
      wait_go_a(found);
      chk("late_first_go_seen", found, 1);
      chk("late_first_grant", a_gid, 0);
      last_go = cyc;
      a_valid = 4'b0010;
      check_frame(2'd0, 8'h10);
      wait_go_a(found);
      chk("late_second_go_seen", found, 1);
      chk("late_spacing", cyc - last_go, A_PERIOD + 1);
      chk("late_ready", a_ready, 4'b0010);
      chk("late_grant", a_gid, 1);
      chk("late_tx_data", a_txd, 8'h77);
      a_valid = 4'b0000;
      $display("late request: grant=%0d data=%02h", a_gid, a_txd);

      // GAP_BITS=0, BAUD_DIV=4: back-to-back requester 2
      b_data = 32'h00C30000;
      b_valid = 4'b0100;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (b_go) begin
            found = 1'b1;
            break;
         end
      end
      chk("gap0_go_seen", found, 1);
      chk("gap0_grant", b_gid, 2);
      chk("gap0_tx_data", b_txd, 8'hC3);
      begin
         int e_be = 0, e_busy = 0, e_go = 0, e_done = 0;
         for (int c = 1; c <= 45; c++) begin
            step();
            if (b_bit_en !== (((c % 4 == 0) && (c < 44)) || c == 45)) e_be++;
            if (b_busy !== (c != 44)) e_busy++;
            if (b_go !== (c == 45)) e_go++;
            if (b_done !== (c == 43)) e_done++;
         end
         chk("gap0_bit_en", e_be, 0);
         chk("gap0_busy_one_idle", e_busy, 0);
         chk("gap0_next_go_t45", e_go, 0);
         chk("gap0_frame_done", e_done, 0);
         chk("gap0_second_grant", b_gid, 2);
      end
      b_valid = 4'b0000;
      $display("gap0 back-to-back: second grant=%0d", b_gid);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
